// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and
// the word-addressed instruction memory (slave).
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, imem handshake,
// one-entry skid buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter int          PC_WIDTH    = 16,
  parameter int          INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   kill,
  input  logic [1:0]             PcSrc,
  input  logic [PC_WIDTH-1:0]    jump_target,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [PC_WIDTH-1:0]    return_addr,
  fetch_stage_if.master          imem,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus1,
  output logic                   if_id_valid,
  output logic [3:0]             if_id_opcode,
  output logic [2:0]             if_id_rd,
  output logic [2:0]             if_id_rs1,
  output logic [2:0]             if_id_rs2
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUF  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0]    PC_ONE   = PC_WIDTH'(1);
  localparam logic [PC_WIDTH-1:0]    PC_ZERO  = PC_WIDTH'(0);
  localparam logic [PC_WIDTH-1:0]    PC_RESET = PC_WIDTH'(RESET_PC);
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = INSTR_WIDTH'(0);

  state_t                 state_r;
  logic                   req_r;
  logic [PC_WIDTH-1:0]    pc_r;
  logic [PC_WIDTH-1:0]    pending_r;
  logic [PC_WIDTH-1:0]    skid_pc_r;
  logic [INSTR_WIDTH-1:0] skid_instr_r;
  logic [INSTR_WIDTH-1:0] if_id_instr_r;
  logic [PC_WIDTH-1:0]    if_id_pc_r;
  logic [PC_WIDTH-1:0]    if_id_pc_plus1_r;
  logic                   if_id_valid_r;
  logic [PC_WIDTH-1:0]    pc_plus1_s;
  logic [PC_WIDTH-1:0]    target_s;

  // Sequential successor and redirect target selected by PcSrc.
  always_comb begin
    pc_plus1_s = pc_r + PC_ONE;
    target_s   = pc_plus1_s;
    case (PcSrc)
      2'd0:    target_s = pc_plus1_s;
      2'd1:    target_s = jump_target;
      2'd2:    target_s = branch_target;
      2'd3:    target_s = return_addr;
      default: target_s = pc_plus1_s;
    endcase
  end

  // Fetch FSM together with PC, skid, pending-target and IF/ID registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      req_r            <= 1'b0;
      pc_r             <= PC_RESET;
      pending_r        <= PC_ZERO;
      skid_pc_r        <= PC_ZERO;
      skid_instr_r     <= NOP_WORD;
      if_id_instr_r    <= NOP_WORD;
      if_id_pc_r       <= PC_ZERO;
      if_id_pc_plus1_r <= PC_ZERO;
      if_id_valid_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if_id_instr_r    <= NOP_WORD;
          if_id_pc_r       <= PC_ZERO;
          if_id_pc_plus1_r <= PC_ZERO;
          if_id_valid_r    <= 1'b0;
          if (kill) begin
            pc_r <= target_s;
          end
          req_r   <= 1'b1;
          state_r <= REQ;
        end

        REQ: begin
          if (kill) begin
            if_id_instr_r    <= NOP_WORD;
            if_id_pc_r       <= PC_ZERO;
            if_id_pc_plus1_r <= PC_ZERO;
            if_id_valid_r    <= 1'b0;
            if (imem.imem_ready) begin
              pc_r <= target_s;
            end else begin
              // The outstanding request must complete at its old address first.
              pending_r <= target_s;
              state_r   <= DROP;
            end
          end else if (stall) begin
            if (imem.imem_ready) begin
              skid_instr_r <= imem.imem_rdata;
              skid_pc_r    <= pc_r;
              pc_r         <= pc_plus1_s;
              req_r        <= 1'b0;
              state_r      <= BUF;
            end
          end else if (imem.imem_ready) begin
            if_id_instr_r    <= imem.imem_rdata;
            if_id_pc_r       <= pc_r;
            if_id_pc_plus1_r <= pc_plus1_s;
            if_id_valid_r    <= 1'b1;
            pc_r             <= pc_plus1_s;
          end else begin
            if_id_instr_r    <= NOP_WORD;
            if_id_pc_r       <= PC_ZERO;
            if_id_pc_plus1_r <= PC_ZERO;
            if_id_valid_r    <= 1'b0;
          end
        end

        BUF: begin
          if (kill) begin
            if_id_instr_r    <= NOP_WORD;
            if_id_pc_r       <= PC_ZERO;
            if_id_pc_plus1_r <= PC_ZERO;
            if_id_valid_r    <= 1'b0;
            skid_instr_r     <= NOP_WORD;
            skid_pc_r        <= PC_ZERO;
            pc_r             <= target_s;
            req_r            <= 1'b1;
            state_r          <= REQ;
          end else if (!stall) begin
            if_id_instr_r    <= skid_instr_r;
            if_id_pc_r       <= skid_pc_r;
            if_id_pc_plus1_r <= skid_pc_r + PC_ONE;
            if_id_valid_r    <= 1'b1;
            skid_instr_r     <= NOP_WORD;
            skid_pc_r        <= PC_ZERO;
            req_r            <= 1'b1;
            state_r          <= REQ;
          end
        end

        DROP: begin
          if_id_instr_r    <= NOP_WORD;
          if_id_pc_r       <= PC_ZERO;
          if_id_pc_plus1_r <= PC_ZERO;
          if_id_valid_r    <= 1'b0;
          if (imem.imem_ready) begin
            pc_r    <= kill ? target_s : pending_r;
            state_r <= REQ;
          end else if (kill) begin
            pending_r <= target_s;
          end
        end

        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;

  assign if_id_instr    = if_id_instr_r;
  assign if_id_pc       = if_id_pc_r;
  assign if_id_pc_plus1 = if_id_pc_plus1_r;
  assign if_id_valid    = if_id_valid_r;
  assign if_id_opcode   = if_id_instr_r[15:12];
  assign if_id_rd       = if_id_instr_r[11:9];
  assign if_id_rs1      = if_id_instr_r[8:6];
  assign if_id_rs2      = if_id_instr_r[5:3];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run scored against an instruction-stream reference model.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        kill;
  logic        ready_drv;
  logic [1:0]  PcSrc;
  logic [15:0] jump_target;
  logic [15:0] branch_target;
  logic [15:0] return_addr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic [3:0]  if_id_opcode;
  logic [2:0]  if_id_rd;
  logic [2:0]  if_id_rs1;
  logic [2:0]  if_id_rs2;
  logic [61:0] obs_s;
  logic [29:0] bub_s;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) bus ();

  // Memory model: word at address a is a + 16'h1000, so mem[i] = 16'h1000 + i.
  assign bus.imem_ready = ready_drv;
  assign bus.imem_rdata = bus.imem_addr + 16'h1000;

  fetch_stage #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .kill           (kill),
    .PcSrc          (PcSrc),
    .jump_target    (jump_target),
    .branch_target  (branch_target),
    .return_addr    (return_addr),
    .imem           (bus),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .if_id_opcode   (if_id_opcode),
    .if_id_rd       (if_id_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2)
  );

  always #5 clk = ~clk;

  assign obs_s = {if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1,
                  if_id_opcode, if_id_rd, if_id_rs1, if_id_rs2};
  assign bub_s = {if_id_valid, if_id_instr, if_id_opcode, if_id_rd, if_id_rs1, if_id_rs2};

  // Expected IF/ID view of a real instruction fetched from address pc.
  function automatic logic [61:0] exp_view(input logic [15:0] pc);
    logic [15:0] w;
    logic [15:0] nxt;
    w   = pc + 16'h1000;
    nxt = pc + 16'd1;
    return {1'b1, w, pc, nxt, w[15:12], w[11:9], w[8:6], w[5:3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    kill          = 1'b0;
    PcSrc         = 2'd0;
    jump_target   = 16'h0000;
    branch_target = 16'h0000;
    return_addr   = 16'h0000;
    ready_drv     = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, obs_s} !== {1'b0, 16'h0000, 62'd0}) begin
      errors++;
      $display("FAIL reset_state: got req=%b addr=%h ifid=%h expected req=0 addr=0000 ifid=0", bus.imem_req, bus.imem_addr, obs_s);
    end
    reset = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_req: got %b expected 0", bus.imem_req);
    end
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", bus.imem_req, bus.imem_addr);
    end
    ready_drv = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req, obs_s} !== {1'b0, 62'd0}) begin
      errors++;
      $display("FAIL reset_mid_req: got req=%b ifid=%h expected req=0 ifid=0", bus.imem_req, obs_s);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs_s !== exp_view(16'(i))) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: got %h expected %h", i, obs_s, exp_view(16'(i)));
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick();
    repeat (6) tick();
    checks++;
    if (obs_s !== exp_view(16'd5)) begin
      errors++;
      $display("FAIL stall_pre: got %h expected %h", obs_s, exp_view(16'd5));
    end
    stall = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, obs_s} !== {1'b0, exp_view(16'd5)}) begin
      errors++;
      $display("FAIL stall_hold1: got req=%b ifid=%h expected req=0 ifid=%h", bus.imem_req, obs_s, exp_view(16'd5));
    end
    tick();
    checks++;
    if (obs_s !== exp_view(16'd5)) begin
      errors++;
      $display("FAIL stall_hold2: got %h expected %h", obs_s, exp_view(16'd5));
    end
    stall = 1'b0;
    for (int i = 6; i < 9; i++) begin
      tick();
      checks++;
      if (obs_s !== exp_view(16'(i))) begin
        errors++;
        $display("FAIL stall_resume[%0d]: got %h expected %h", i, obs_s, exp_view(16'(i)));
      end
    end
  endtask

  task automatic test_kill_branch();
    do_reset();
    tick();
    repeat (9) tick();
    kill          = 1'b1;
    PcSrc         = 2'd2;
    branch_target = 16'h0040;
    tick();
    checks++;
    if (bub_s !== 30'd0) begin
      errors++;
      $display("FAIL kill_bubble: got %h expected 0", bub_s);
    end
    kill = 1'b0;
    tick();
    checks++;
    if (obs_s !== exp_view(16'h0040)) begin
      errors++;
      $display("FAIL kill_target: got %h expected %h", obs_s, exp_view(16'h0040));
    end
  endtask

  task automatic test_drop();
    do_reset();
    tick();
    repeat (3) tick();
    ready_drv   = 1'b0;
    kill        = 1'b1;
    PcSrc       = 2'd1;
    jump_target = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      kill = 1'b0;
      checks++;
      if ({bus.imem_req, bus.imem_addr, bub_s} !== {1'b1, 16'h0003, 30'd0}) begin
        errors++;
        $display("FAIL drop_wait[%0d]: got req=%b addr=%h bub=%h expected req=1 addr=0003 bub=0", i, bus.imem_req, bus.imem_addr, bub_s);
      end
    end
    ready_drv = 1'b1;
    tick();
    checks++;
    if ({bus.imem_req, bus.imem_addr, bub_s} !== {1'b1, 16'h0100, 30'd0}) begin
      errors++;
      $display("FAIL drop_done: got req=%b addr=%h bub=%h expected req=1 addr=0100 bub=0", bus.imem_req, bus.imem_addr, bub_s);
    end
    tick();
    checks++;
    if (obs_s !== exp_view(16'h0100)) begin
      errors++;
      $display("FAIL drop_target: got %h expected %h", obs_s, exp_view(16'h0100));
    end
  endtask

  task automatic test_kill_stall();
    do_reset();
    tick();
    repeat (3) tick();
    kill        = 1'b1;
    stall       = 1'b1;
    PcSrc       = 2'd3;
    return_addr = 16'h0022;
    tick();
    checks++;
    if (bub_s !== 30'd0) begin
      errors++;
      $display("FAIL killstall_bubble: got %h expected 0", bub_s);
    end
    kill  = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_s !== exp_view(16'(16'h0022 + i))) begin
        errors++;
        $display("FAIL killstall_fetch[%0d]: got %h expected %h", i, obs_s, exp_view(16'(16'h0022 + i)));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    kill        = 1'b1;
    PcSrc       = 2'd1;
    jump_target = 16'hFFFF;
    tick();
    kill = 1'b0;
    tick();
    checks++;
    if (obs_s !== {1'b1, 16'h0FFF, 16'hFFFF, 16'h0000, 4'h0, 3'd7, 3'd7, 3'd7}) begin
      errors++;
      $display("FAIL wrap_ffff: got %h expected pc=ffff pc_plus1=0000", obs_s);
    end
    tick();
    checks++;
    if (obs_s !== exp_view(16'h0000)) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected %h", obs_s, exp_view(16'h0000));
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] tgt;
    logic [15:0] prev_addr;
    logic [61:0] prev_obs;
    logic        prev_req;
    logic        k;
    logic        s;
    logic        r;
    logic [1:0]  src;
    int          delivered;
    do_reset();
    exp_pc    = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      s             = ($urandom_range(0, 3) == 0);
      k             = ($urandom_range(0, 11) == 0);
      r             = ($urandom_range(0, 9) < 6);
      src           = 2'($urandom_range(1, 3));
      jump_target   = 16'($urandom);
      branch_target = 16'($urandom);
      return_addr   = 16'($urandom);
      stall         = s;
      kill          = k;
      PcSrc         = src;
      ready_drv     = r;
      tgt = (src == 2'd1) ? jump_target : ((src == 2'd2) ? branch_target : return_addr);
      prev_obs  = obs_s;
      prev_req  = bus.imem_req;
      prev_addr = bus.imem_addr;
      tick();
      checks++;
      if (k) begin
        if (bub_s !== 30'd0) begin
          errors++;
          $display("FAIL rnd_kill_bubble[%0d]: got %h expected 0", c, bub_s);
        end
        exp_pc = tgt;
      end else if (s) begin
        if (obs_s !== prev_obs) begin
          errors++;
          $display("FAIL rnd_stall_hold[%0d]: got %h expected %h", c, obs_s, prev_obs);
        end
      end else if (if_id_valid) begin
        if (obs_s !== exp_view(exp_pc)) begin
          errors++;
          $display("FAIL rnd_stream[%0d]: got %h expected %h", c, obs_s, exp_view(exp_pc));
        end
        exp_pc = exp_pc + 16'd1;
        delivered++;
      end else begin
        if (bub_s !== 30'd0) begin
          errors++;
          $display("FAIL rnd_bubble[%0d]: got %h expected 0", c, bub_s);
        end
      end
      if (prev_req && !r) begin
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin
          errors++;
          $display("FAIL rnd_addr_stable[%0d]: got req=%b addr=%h expected req=1 addr=%h", c, bus.imem_req, bus.imem_addr, prev_addr);
        end
      end
    end
    checks++;
    if (delivered < 300) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d deliveries expected at least 300", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_kill_branch();
    test_drop();
    test_kill_stall();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined processor, directly upstream of decode/control.
- Owns the PC register, the next-PC selection and the word-addressed instruction-memory request/ready handshake.
- Holds a 1-entry skid buffer and the IF/ID pipeline register.
- Consumes PcSrc/kill from the PC controller and stall from hazard detection; produces the instruction, its PC and PC+1 for decode.

Parameters:
- PC_WIDTH, 16, PC and instruction-memory address width (word addressing).
- INSTR_WIDTH, 16, instruction word width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard).
- kill  in  1  redirect; flush younger instruction.
- PcSrc  in  2  next-PC select: 0 = PC+1, 1 = jump_target, 2 = branch_target, 3 = return_addr.
- jump_target  in  PC_WIDTH  JMP/CALL target from decode.
- branch_target  in  PC_WIDTH  taken-branch target.
- return_addr  in  PC_WIDTH  RET target.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  imem_rdata valid for the current request this cycle.
- imem_rdata  in  INSTR_WIDTH  fetched word.
- if_id_instr  out  INSTR_WIDTH  instruction to decode.
- if_id_pc  out  PC_WIDTH  address of if_id_instr.
- if_id_pc_plus1  out  PC_WIDTH  if_id_pc+1 (CALL link value).
- if_id_valid  out  1  if_id_instr is real (0 = bubble).
- if_id_opcode  out  4  if_id_instr[15:12].
- if_id_rd  out  3  if_id_instr[11:9].
- if_id_rs1  out  3  if_id_instr[8:6].
- if_id_rs2  out  3  if_id_instr[5:3].

Behaviour:
- Reset (async): pc=RESET_PC, FSM=IDLE, skid empty, if_id_instr=0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, imem_req=0.
- Bubble encoding: instr=16'h0000 (AND R0,R0,R0, harmless because R0 is hardwired zero) with valid=0.
- Redirect target when kill=1: PcSrc 0 = pc+1, 1 = jump_target, 2 = branch_target, 3 = return_addr. When kill=0, PcSrc is ignored and the next PC is pc+1.
- PC+1 wraps modulo 2^PC_WIDTH (16'hFFFF -> 16'h0000).
- FSM states:
  - IDLE: first cycle after reset deassert; imem_req=0; go to REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ready with stall=0 and kill=0: IF/ID <= {rdata, pc, pc+1, valid=1}; pc <= pc+1; stay in REQ. Back-to-back throughput is 1 instruction per cycle.
    - On imem_ready with stall=1: capture {rdata, pc} into skid; pc <= pc+1; go to BUF with imem_req=0.
    - While imem_ready=0 and stall=0: IF/ID <= bubble.
  - BUF: imem_req=0; on stall=0, IF/ID <= skid contents (valid=1), skid empty, go to REQ.
  - DROP: a redirect arrived while a request was outstanding. Keep imem_req=1 with the old address until imem_ready, discard the data, then pc <= pending target and go to REQ. IF/ID receives a bubble every DROP cycle.
- Stall (kill=0): PC and IF/ID hold their values; no new request is issued once the skid is full.
- Kill (takes priority over stall and imem_ready):
  - IF/ID <= bubble next edge; skid emptied.
  - In REQ with imem_ready=0: latch target into pending register, go to DROP.
  - In REQ with imem_ready=1: discard rdata, pc <= target, stay in REQ.
  - In IDLE or BUF: pc <= target, go to REQ.
  - In DROP: overwrite pending target with the newest target.
- Priority: reset > kill > stall > normal advance.
- Field outputs are combinational slices of the registered if_id_instr.
- Reset asserted mid-request drops the outstanding request without waiting for imem_ready. The memory must tolerate an abandoned request.

Test Plan:
- Reset release, imem_ready tied 1, mem[i]=16'h1000+i -> imem_req rises one cycle after reset release; if_id_pc = 0,1,2,3 on successive cycles; if_id_valid=1; instr=16'h1000..16'h1003.
- Stall high for 2 cycles while IF/ID holds pc=5 -> IF/ID stays pc=5, then the next cycle shows pc=6. The pc=6 word is delivered from the skid; no duplicate and no skipped word.
- kill=1, PcSrc=2, branch_target=16'h0040 while at pc=8 -> next IF/ID is a bubble (valid=0, instr=0); the following instruction has pc=16'h0040.
- imem_ready low 3 cycles at pc=3, kill with PcSrc=1, jump_target=16'h0100 in cycle 1 -> imem_addr stays 3 until ready; the word is discarded; next request address is 16'h0100; all intermediate IF/ID entries are bubbles.
- kill and stall asserted together, PcSrc=3, return_addr=16'h0022 -> kill wins: flush, then fetch 16'h0022.
- PC at 16'hFFFF, no redirect -> next if_id_pc=16'h0000; if_id_pc_plus1 for 16'hFFFF is 16'h0000.
